// File: rtl/fp_formats_pkg.sv
// Shared numeric-format definitions for the systolic array and the
// scheduler that feeds it.
package fp_formats_pkg;

  typedef enum logic [1:0] {
    FP8_E4M3 = 2'b00,
    FP8_E5M2 = 2'b01,
    BF16     = 2'b10
  } fp_mode_e;

  localparam logic [1:0] FP_MODE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRAIN = 2'b01,
    CFG   = 2'b10,
    ISSUE = 2'b11
  } sched_state_e;

endpackage

// File: rtl/fp_mode_scheduler_drain_timer.sv
// Tracks how long the array pipeline still holds work: reloads on every
// accepted beat, otherwise counts down and sticks at zero.
module fp_drain_timer #(
  parameter int ARRAY_LAT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic cnt_zero
);

  localparam int CW = $clog2(ARRAY_LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = CW'(ARRAY_LAT);
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/fp_mode_scheduler.sv
// Feeds tile jobs into the systolic array, reconfiguring its numeric format
// only once the pipeline has drained.
module fp_mode_scheduler
  import fp_formats_pkg::*;
#(
  parameter int ARRAY_LAT  = 16,
  parameter int SWITCH_CYC = 2,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [1:0]       job_mode,
  input  logic [LEN_W-1:0] job_len,
  output logic [1:0]       arr_mode,
  output logic             arr_cfg_we,
  output logic             arr_beat_valid,
  input  logic             arr_beat_ready,
  output logic             arr_last,
  output logic             busy,
  output logic             err_mode
);

  localparam int SW = $clog2(SWITCH_CYC + 1);

  sched_state_e     state_q, state_d;
  fp_mode_e         mode_q, mode_d;
  logic [1:0]       arr_mode_q, arr_mode_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic [SW-1:0]    cfg_cnt_q, cfg_cnt_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             cfg_we_q, cfg_we_d;
  logic             beat_valid_q, beat_valid_d;
  logic             err_q, err_d;
  logic             hs, drain_zero;

  assign hs = beat_valid_q & arr_beat_ready;

  fp_drain_timer #(.ARRAY_LAT(ARRAY_LAT)) u_drain (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hs),
    .cnt_zero (drain_zero)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    arr_mode_d  = arr_mode_q;
    cfg_valid_d = cfg_valid_q;
    cfg_cnt_d   = cfg_cnt_q;
    remaining_d = remaining_q;
    err_d       = 1'b0;
    if (hs) remaining_d = remaining_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (job_valid) begin
          if (job_mode == FP_MODE_ILLEGAL) begin
            err_d = 1'b1;
          end else if (job_len != '0) begin
            remaining_d = job_len;
            if (!cfg_valid_q || job_mode != arr_mode_q) begin
              mode_d  = fp_mode_e'(job_mode);
              state_d = drain_zero ? CFG : DRAIN;
            end else begin
              state_d = ISSUE;
            end
          end
        end
      end
      DRAIN: if (drain_zero) state_d = CFG;
      CFG: begin
        if (cfg_cnt_q == SW'(SWITCH_CYC - 1)) begin
          state_d     = ISSUE;
          cfg_valid_d = 1'b1;
          cfg_cnt_d   = '0;
        end else begin
          cfg_cnt_d = cfg_cnt_q + 1'b1;
        end
      end
      ISSUE: if (hs && remaining_q == LEN_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Format is committed on the edge that enters CFG; straight from IDLE the
    // latched copy is not yet written, so take it from the request.
    if (state_d == CFG && state_q != CFG)
      arr_mode_d = (state_q == IDLE) ? job_mode : mode_q;
    cfg_we_d     = (state_d == CFG);
    beat_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= FP8_E4M3;
      arr_mode_q   <= 2'b00;
      cfg_valid_q  <= 1'b0;
      cfg_cnt_q    <= '0;
      remaining_q  <= '0;
      cfg_we_q     <= 1'b0;
      beat_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      arr_mode_q   <= arr_mode_d;
      cfg_valid_q  <= cfg_valid_d;
      cfg_cnt_q    <= cfg_cnt_d;
      remaining_q  <= remaining_d;
      cfg_we_q     <= cfg_we_d;
      beat_valid_q <= beat_valid_d;
      err_q        <= err_d;
    end
  end

  assign job_ready      = (state_q == IDLE);
  assign arr_mode       = arr_mode_q;
  assign arr_cfg_we     = cfg_we_q;
  assign arr_beat_valid = beat_valid_q;
  assign arr_last       = beat_valid_q & (remaining_q == LEN_W'(1));
  assign busy           = (state_q != IDLE) | ~drain_zero;
  assign err_mode       = err_q;

endmodule

// File: tb/tb_fp_mode_scheduler.sv
// Directed bench for fp_mode_scheduler: a per-cycle vector table for the
// reconfigure / back-to-back / drain flows, then hand-written corner cases.
module tb_fp_mode_scheduler;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             job_valid;
  logic             job_ready;
  logic [1:0]       job_mode;
  logic [LEN_W-1:0] job_len;
  logic [1:0]       arr_mode;
  logic             arr_cfg_we;
  logic             arr_beat_valid;
  logic             arr_beat_ready;
  logic             arr_last;
  logic             busy;
  logic             err_mode;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  fp_mode_scheduler #(.ARRAY_LAT(4), .SWITCH_CYC(2), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_mode       (job_mode),
    .job_len        (job_len),
    .arr_mode       (arr_mode),
    .arr_cfg_we     (arr_cfg_we),
    .arr_beat_valid (arr_beat_valid),
    .arr_beat_ready (arr_beat_ready),
    .arr_last       (arr_last),
    .busy           (busy),
    .err_mode       (err_mode)
  );

  // expected vector: {job_ready, arr_mode[1:0], cfg_we, beat_valid, last, busy, err}
  typedef struct {
    logic       rst;
    logic       jv;
    logic [1:0] jm;
    logic [LEN_W-1:0] jl;
    logic       rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic jv, input logic [1:0] jm, input int jl,
                     input logic rdy, input logic jr, input logic [1:0] am, input logic we,
                     input logic bv, input logic lst, input logic bsy, input logic er);
    vec_t v;
    v.rst = r; v.jv = jv; v.jm = jm; v.jl = LEN_W'(jl); v.rdy = rdy;
    v.exp = {jr, am, we, bv, lst, bsy, er};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {job_ready, arr_mode, arr_cfg_we, arr_beat_valid, arr_last, busy, err_mode};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, hs_cnt, last_cnt, we_cnt;
    logic [8:0] pat;

    rst_n = 1'b0; job_valid = 1'b0; job_mode = 2'b00; job_len = '0; arr_beat_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // test 1: BF16 len 3 from reset
    add(0,0,0,0,1, 1,0,0,0,0,0,0);
    add(1,1,2,3,1, 1,0,0,0,0,0,0);
    repeat (2) add(1,0,0,0,1, 0,2,1,0,0,1,0);
    repeat (2) add(1,0,0,0,1, 0,2,0,1,0,1,0);
    add(1,0,0,0,1, 0,2,0,1,1,1,0);
    repeat (4) add(1,0,0,0,1, 1,2,0,0,0,1,0);
    // test 2: E4M3 len 2 twice (first reconfigures away from BF16)
    add(1,1,0,2,1, 1,2,0,0,0,0,0);
    repeat (2) add(1,0,0,0,1, 0,0,1,0,0,1,0);
    add(1,1,0,2,1, 0,0,0,1,0,1,0);
    add(1,1,0,2,1, 0,0,0,1,1,1,0);
    add(1,1,0,2,1, 1,0,0,0,0,1,0);
    // test 3: E4M3 len 2 (same mode) then E5M2 len 1 must drain first
    add(1,1,0,2,1, 0,0,0,1,0,1,0);
    add(1,1,0,2,1, 0,0,0,1,1,1,0);
    add(1,1,0,2,1, 1,0,0,0,0,1,0);
    add(1,1,1,1,1, 0,0,0,1,0,1,0);
    add(1,1,1,1,1, 0,0,0,1,1,1,0);
    add(1,1,1,1,1, 1,0,0,0,0,1,0);
    repeat (4) add(1,0,0,0,1, 0,0,0,0,0,1,0);
    repeat (2) add(1,0,0,0,1, 0,1,1,0,0,1,0);
    add(1,0,0,0,1, 0,1,0,1,1,1,0);
    repeat (4) add(1,0,0,0,1, 1,1,0,0,0,1,0);
    add(1,0,0,0,1, 1,1,0,0,0,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      if (i != 0) cyc();
      rst_n = vq[i].rst; job_valid = vq[i].jv; job_mode = vq[i].jm;
      job_len = vq[i].jl; arr_beat_ready = vq[i].rdy;
      chk($sformatf("row%0d", i), 32'(outs()), 32'(vq[i].exp));
    end

    // test 4: BF16 len 5 under backpressure
    cyc();
    job_valid = 1'b1; job_mode = 2'b10; job_len = 16'd5;
    cyc();
    job_valid = 1'b0;
    n = 0;
    while (!arr_beat_valid && n < 10) begin cyc(); n++; end
    chk("t4_start", 32'(arr_beat_valid), 32'd1);
    chk("t4_mode", 32'(arr_mode), 32'd2);
    pat = 9'b1_0110_1001;
    hs_cnt = 0; last_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      arr_beat_ready = pat[i];
      #1;
      chk($sformatf("t4_valid%0d", i), 32'(arr_beat_valid), 32'd1);
      chk($sformatf("t4_last%0d", i), 32'(arr_last), 32'(hs_cnt == 4));
      if (arr_beat_valid && arr_beat_ready) begin
        hs_cnt++;
        if (arr_last) last_cnt++;
      end
      cyc();
    end
    arr_beat_ready = 1'b1;
    chk("t4_hs", 32'(hs_cnt), 32'd5);
    chk("t4_last_hs", 32'(last_cnt), 32'd1);
    chk("t4_end", 32'(arr_beat_valid), 32'd0);

    // test 5: illegal mode, then zero-length job
    n = 0;
    while (busy && n < 20) begin cyc(); n++; end
    chk("t5_idle", 32'(busy), 32'd0);
    job_valid = 1'b1; job_mode = 2'b11; job_len = 16'd4;
    cyc();
    job_valid = 1'b0;
    chk("t5_err", 32'(outs()), 32'({1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    cyc();
    chk("t5_err_clr", 32'(outs()), 32'({1'b1, 2'b10, 5'b0}));
    job_valid = 1'b1; job_mode = 2'b00; job_len = '0;
    cyc();
    job_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_len0_%0d", i), 32'(outs()), 32'({1'b1, 2'b10, 5'b0}));
      cyc();
    end

    // test 6: reset during the second beat of E5M2 len 6
    job_valid = 1'b1; job_mode = 2'b01; job_len = 16'd6;
    cyc();
    job_valid = 1'b0;
    n = 0;
    while (!arr_beat_valid && n < 10) begin cyc(); n++; end
    chk("t6_start", 32'(arr_beat_valid), 32'd1);
    cyc();
    chk("t6_beat2", 32'({arr_beat_valid, arr_mode}), 32'({1'b1, 2'b01}));
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t6_reset", 32'(outs()), 32'({1'b1, 7'b0}));
    job_valid = 1'b1; job_mode = 2'b01; job_len = 16'd1;
    cyc();
    job_valid = 1'b0;
    chk("t6_cfg_mode", 32'({arr_cfg_we, arr_mode}), 32'({1'b1, 2'b01}));
    we_cnt = 0; n = 0;
    while (!arr_beat_valid && n < 10) begin
      if (arr_cfg_we) we_cnt++;
      cyc(); n++;
    end
    chk("t6_we_cycles", 32'(we_cnt), 32'd2);
    chk("t6_last", 32'({arr_beat_valid, arr_last}), 32'({1'b1, 1'b1}));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
